// File: rtl/cnt_capture.sv
// Timestamp capture: extends an 8-bit counter to 16 bits via its carry-out and
// snapshots {wrap_cnt, cnt_in} on evt rising edges into a FWFT valid/ready FIFO.
module cnt_capture #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cnt_in,
  input  logic          cout_in,
  input  logic          load_in,
  input  logic          evt,
  output logic [15:0]   cap_data,
  output logic          cap_valid,
  input  logic          cap_ready,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    wrap_cnt;
  logic          evt_q;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_req;
  logic          pop;
  logic          push;

  always_comb begin
    push_req = evt & ~evt_q;
    pop      = cap_valid & cap_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    push     = push_req & ((count != FULL) | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt <= '0;
      evt_q    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (load_in)
        wrap_cnt <= '0;
      else if (cout_in)
        wrap_cnt <= wrap_cnt + 8'd1;

      evt_q <= evt;

      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (push_req & ~push)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // storage is not reset; its content is don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= {wrap_cnt, cnt_in};
  end

  assign cap_data  = mem[rd_ptr];
  assign cap_valid = (count != '0);
  assign level     = count;

endmodule

// File: tb/tb_cnt_capture.sv
// Directed and randomized bench for cnt_capture against a queue-based model.
module tb_cnt_capture;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    cnt_in = '0;
  logic          cout_in = 1'b0;
  logic          load_in = 1'b0;
  logic          evt = 1'b0;
  logic [15:0]   cap_data;
  logic          cap_valid;
  logic          cap_ready = 1'b0;
  logic [AW:0]   level;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  cnt_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cout_in(cout_in),
    .load_in(load_in), .evt(evt), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // bench-side upstream counter and control
  logic [7:0] cnt = '0;
  logic [7:0] ld_val = '0;
  logic       cin = 1'b0;
  logic       cout_force = 1'b0;

  // reference model
  logic [15:0] q[$];
  int          m_wrap = 0;
  bit          m_evt_prev = 1'b1;
  bit          m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] snap;
    bit          rising;
    cnt_in  = cnt;
    cout_in = cout_force | (cin & (cnt == 8'hFF));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_wrap     = 0;
      m_evt_prev = 1'b1;
      m_ovf      = 1'b0;
    end else begin
      snap   = {8'(m_wrap), cnt_in};
      rising = evt && !m_evt_prev;
      if (q.size() > 0 && cap_ready)
        void'(q.pop_front());
      if (rising) begin
        if (q.size() < DEPTH) q.push_back(snap);
        else m_ovf = 1'b1;
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
      end
      if (rising && q.size() == DEPTH && ovf_clr && m_ovf) m_ovf = 1'b1;
      if (load_in) m_wrap = 0;
      else if (cout_in) m_wrap = (m_wrap + 1) % 256;
      m_evt_prev = evt;
    end
    if (load_in) cnt = ld_val;
    else if (cin) cnt = cnt + 8'd1;
    @(negedge clk);
    chk("cap_valid", 32'(cap_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (q.size() != 0) chk("cap_data", 32'(cap_data), 32'(q[0]));
  endtask

  task automatic load_cnt(input logic [7:0] v);
    ld_val = v; load_in = 1'b1; tick(); load_in = 1'b0;
  endtask

  task automatic pulse_evt();
    evt = 1'b1; tick(); evt = 1'b0; tick();
  endtask

  task automatic drain_expect(input logic [15:0] v, input string tag);
    cap_ready = 1'b1;
    chk(tag, 32'(cap_data), 32'(v));
    tick();
    cap_ready = 1'b0;
  endtask

  initial begin
    int guard;
    logic [15:0] exp_ord [4];

    // reset held with evt high, then released with evt still high
    rst = 1'b1; evt = 1'b1; cap_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_valid", 32'(cap_valid), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
      chk("idle_ovf", 32'(ovf), 32'd0);
    end
    evt = 1'b0; tick();

    // wrap extension across 0xFF -> 0x00
    cin = 1'b1;
    load_cnt(8'hFE);
    guard = 0;
    while (cnt != 8'h03 && guard < 300) begin tick(); guard++; end
    chk("wrap_reach", 32'(guard < 300), 32'd1);
    evt = 1'b1; tick(); evt = 1'b0; cin = 1'b0; tick();
    chk("wrap_cap", 32'(cap_data), 32'h0103);
    drain_expect(16'h0103, "wrap_drain");

    // load and carry in the same cycle: load wins
    cout_force = 1'b1; ld_val = 8'h20; load_in = 1'b1; tick();
    cout_force = 1'b0; load_in = 1'b0;
    pulse_evt();
    chk("ldpri_cap", 32'(cap_data), 32'h0020);
    drain_expect(16'h0020, "ldpri_drain");

    // fill, overflow, drain in order
    exp_ord = '{16'h0010, 16'h0012, 16'h0014, 16'h0016};
    for (int i = 0; i < 5; i++) begin
      load_cnt(8'(8'h10 + 2 * i));
      pulse_evt();
      if (i == 3) begin
        chk("full_level", 32'(level), 32'd4);
        chk("full_valid", 32'(cap_valid), 32'd1);
      end
    end
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_set", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) drain_expect(exp_ord[i], "ovf_drain");
    chk("drained", 32'(level), 32'd0);

    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // push while full with simultaneous pop
    for (int i = 0; i < 4; i++) begin load_cnt(8'(8'h24 + 2 * i)); pulse_evt(); end
    load_cnt(8'h30);
    evt = 1'b1; cap_ready = 1'b1; tick();
    evt = 1'b0; cap_ready = 1'b0;
    chk("pwf_level", 32'(level), 32'd4);
    chk("pwf_ovf", 32'(ovf), 32'd0);
    tick();
    exp_ord = '{16'h0026, 16'h0028, 16'h002A, 16'h0030};
    for (int i = 0; i < 4; i++) drain_expect(exp_ord[i], "pwf_drain");

    // drop coincident with ovf_clr: set wins
    for (int i = 0; i < 4; i++) begin load_cnt(8'(8'h40 + i)); pulse_evt(); end
    evt = 1'b1; ovf_clr = 1'b1; tick(); evt = 1'b0; ovf_clr = 1'b0;
    chk("setwin_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);

    // mid-operation reset discards queued entries
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin load_cnt(8'(8'h50 + i)); pulse_evt(); end
    chk("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(cap_valid), 32'd0);
    tick();
    ld_val = 8'h05; load_in = 1'b0; cnt = 8'h05;
    pulse_evt();
    chk("post_rst_cap", 32'(cap_data), 32'h0005);
    drain_expect(16'h0005, "post_rst_drain");

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      evt        = ($urandom_range(0, 2) == 0);
      cap_ready  = ($urandom_range(0, 2) != 0);
      cin        = ($urandom_range(0, 1) == 1);
      load_in    = ($urandom_range(0, 19) == 0);
      ld_val     = 8'($urandom_range(0, 255));
      cout_force = ($urandom_range(0, 39) == 0);
      ovf_clr    = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; load_in = 1'b0; cout_force = 1'b0; ovf_clr = 1'b0; evt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
